// File: rtl/pixel_plot_fifo.sv
// Plot-request FIFO feeding a VGA adapter, with a full-screen clear sweep; pop-to-write latency 1 cycle, 1 pixel/cycle.
// Back-pressure: in_ready drops when the FIFO is full or while waiting for it to drain before a clear.
module pixel_plot_fifo #(
    parameter int DEPTH = 8,
    parameter int X_MAX = 320,
    parameter int Y_MAX = 240
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [8:0] in_x,
    input  logic [7:0] in_y,
    input  logic [2:0] in_colour,
    input  logic       clear_req,
    input  logic [2:0] clear_colour,
    output logic       vga_write,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       clear_busy,
    output logic [4:0] level,
    output logic [7:0] clip_count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [8:0] X_LAST = 9'(X_MAX - 1);
    localparam logic [7:0] Y_LAST = 8'(Y_MAX - 1);

    typedef enum logic [1:0] {S_RUN, S_WAIT_EMPTY, S_CLEAR} state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [19:0]     r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [4:0]      r_level;
    logic [7:0]      r_clip;
    logic [2:0]      r_clr_colour;
    logic [8:0]      r_sx;
    logic [7:0]      r_sy;
    logic            r_vga_write;
    logic [8:0]      r_vga_x;
    logic [7:0]      r_vga_y;
    logic [2:0]      r_vga_colour;
    logic            r_clear_busy;

    logic            w_in_ready;
    logic            w_push;
    logic            w_clip;
    logic            w_store;
    logic            w_pop;
    logic            w_sweep_last;

    assign w_in_ready   = (r_state != S_WAIT_EMPTY) && (r_level < 5'(DEPTH));
    assign w_push       = in_valid && w_in_ready;
    assign w_clip       = ({1'b0, in_x} >= 10'(X_MAX)) || ({1'b0, in_y} >= 9'(Y_MAX));
    assign w_store      = w_push && !w_clip;
    assign w_pop        = (r_state != S_CLEAR) && (r_level != 5'd0);
    assign w_sweep_last = (r_sx == X_LAST) && (r_sy == Y_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN:        if (clear_req)          w_state_nxt = S_WAIT_EMPTY;
            S_WAIT_EMPTY: if (r_level == 5'd0)    w_state_nxt = S_CLEAR;
            S_CLEAR:      if (w_sweep_last)       w_state_nxt = S_RUN;
            default:                              w_state_nxt = S_RUN;
        endcase
    end

    // Storage array carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        if (w_store) r_mem[r_wr_ptr] <= {in_x, in_y, in_colour};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_RUN;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_level      <= '0;
            r_clip       <= '0;
            r_clr_colour <= '0;
            r_sx         <= '0;
            r_sy         <= '0;
            r_vga_write  <= 1'b0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_colour <= '0;
            r_clear_busy <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_clear_busy <= (w_state_nxt != S_RUN);
            if (w_store) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + 5'(w_store) - 5'(w_pop);
            if (w_push && w_clip && (r_clip != 8'hFF)) r_clip <= r_clip + 8'd1;
            if ((r_state == S_RUN) && clear_req) r_clr_colour <= clear_colour;

            if (w_pop) begin
                r_vga_write <= 1'b1;
                {r_vga_x, r_vga_y, r_vga_colour} <= r_mem[r_rd_ptr];
            end else if (r_state == S_CLEAR) begin
                r_vga_write  <= 1'b1;
                r_vga_x      <= r_sx;
                r_vga_y      <= r_sy;
                r_vga_colour <= r_clr_colour;
            end else begin
                r_vga_write <= 1'b0;
            end

            // Sweep origin is re-armed while waiting so every clear starts at (0,0).
            if (r_state == S_WAIT_EMPTY) begin
                r_sx <= '0;
                r_sy <= '0;
            end else if (r_state == S_CLEAR) begin
                if (r_sx == X_LAST) begin
                    r_sx <= '0;
                    r_sy <= r_sy + 8'd1;
                end else begin
                    r_sx <= r_sx + 9'd1;
                end
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign vga_write  = r_vga_write;
    assign vga_x      = r_vga_x;
    assign vga_y      = r_vga_y;
    assign vga_colour = r_vga_colour;
    assign clear_busy = r_clear_busy;
    assign level      = r_level;
    assign clip_count = r_clip;
endmodule

// File: tb/tb_pixel_plot_fifo.sv
// Randomised bench for pixel_plot_fifo: a queue of expected VGA writes checked by a write monitor.
module tb_pixel_plot_fifo;
    localparam int DP = 8;
    localparam int XM = 40;
    localparam int YM = 30;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [8:0] in_x = '0;
    logic [7:0] in_y = '0;
    logic [2:0] in_colour = '0;
    logic       clear_req = 1'b0;
    logic [2:0] clear_colour = '0;
    logic       vga_write;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       clear_busy;
    logic [4:0] level;
    logic [7:0] clip_count;

    int          total = 0;
    int          bad = 0;
    int          exp_clip = 0;
    logic [19:0] exp_q[$];
    logic [19:0] mon_e;

    pixel_plot_fifo #(.DEPTH(DP), .X_MAX(XM), .Y_MAX(YM)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_x(in_x), .in_y(in_y), .in_colour(in_colour),
        .clear_req(clear_req), .clear_colour(clear_colour),
        .vga_write(vga_write), .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .clear_busy(clear_busy), .level(level), .clip_count(clip_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Every observed write must be the oldest outstanding expected pixel.
    always @(negedge clk) begin
        if (!reset && vga_write) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL vga_unexpected got=(%0d,%0d,%0d) want=no write", vga_x, vga_y, vga_colour);
            end else begin
                mon_e = exp_q.pop_front();
                if ({vga_x, vga_y, vga_colour} !== mon_e) begin
                    bad++;
                    $display("FAIL vga_pixel got=(%0d,%0d,%0d) want=(%0d,%0d,%0d)",
                             vga_x, vga_y, vga_colour, mon_e[19:11], mon_e[10:3], mon_e[2:0]);
                end
            end
        end
    end

    task automatic model_accept(input logic [8:0] x, input logic [7:0] y, input logic [2:0] c);
        if (int'(x) >= XM || int'(y) >= YM) begin
            if (exp_clip < 255) exp_clip++;
        end else begin
            exp_q.push_back({x, y, c});
        end
    endtask

    // Called at a falling edge; returns at the next falling edge with in_valid low.
    task automatic push(input logic [8:0] x, input logic [7:0] y, input logic [2:0] c, output bit acc);
        in_valid = 1'b1; in_x = x; in_y = y; in_colour = c;
        #1;
        acc = in_ready;
        if (acc) model_accept(x, y, c);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic issue_clear(input logic [2:0] c, input bit takes_effect);
        clear_req = 1'b1; clear_colour = c;
        if (takes_effect)
            for (int yy = 0; yy < YM; yy++)
                for (int xx = 0; xx < XM; xx++)
                    exp_q.push_back({9'(xx), 8'(yy), c});
        @(posedge clk);
        @(negedge clk);
        clear_req = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string name);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s_drain got=%0d pending want=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic apply_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        exp_q.delete();
        exp_clip = 0;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(negedge clk);
        total++; if (vga_write !== 1'b0)  begin bad++; $display("FAIL reset_vga_write got=%0b want=0", vga_write); end
        total++; if (vga_x !== 9'd0)      begin bad++; $display("FAIL reset_vga_x got=%0d want=0", vga_x); end
        total++; if (vga_y !== 8'd0)      begin bad++; $display("FAIL reset_vga_y got=%0d want=0", vga_y); end
        total++; if (vga_colour !== 3'd0) begin bad++; $display("FAIL reset_vga_colour got=%0d want=0", vga_colour); end
        total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL reset_clear_busy got=%0b want=0", clear_busy); end
        total++; if (level !== 5'd0)      begin bad++; $display("FAIL reset_level got=%0d want=0", level); end
        total++; if (clip_count !== 8'd0) begin bad++; $display("FAIL reset_clip got=%0d want=0", clip_count); end
        total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_push;
        bit acc;
        push(9'd10, 8'd20, 3'd5, acc);
        total++; if (acc !== 1'b1)      begin bad++; $display("FAIL single_accept got=%0b want=1", acc); end
        total++; if (vga_write !== 1'b0) begin bad++; $display("FAIL single_early_write got=%0b want=0", vga_write); end
        total++; if (level !== 5'd1)    begin bad++; $display("FAIL single_level1 got=%0d want=1", level); end
        @(negedge clk);
        total++; if ({vga_write, vga_x, vga_y, vga_colour} !== {1'b1, 9'd10, 8'd20, 3'd5})
            begin bad++; $display("FAIL single_write got=%0b(%0d,%0d,%0d) want=1(10,20,5)", vga_write, vga_x, vga_y, vga_colour); end
        @(negedge clk);
        total++; if (vga_write !== 1'b0) begin bad++; $display("FAIL single_one_shot got=%0b want=0", vga_write); end
        total++; if (level !== 5'd0)    begin bad++; $display("FAIL single_level0 got=%0d want=0", level); end
    endtask

    task automatic test_back_to_back;
        bit acc;
        int n_acc = 0;
        for (int i = 0; i < 30; i++) begin
            push(9'($urandom_range(XM - 1)), 8'($urandom_range(YM - 1)), 3'($urandom), acc);
            if (acc) n_acc++;
            total++; if (level > 5'd1) begin bad++; $display("FAIL b2b_level got=%0d want<=1", level); end
        end
        total++; if (n_acc != 30) begin bad++; $display("FAIL b2b_accepted got=%0d want=30", n_acc); end
        wait_drain(50, "b2b");
    endtask

    task automatic test_random_stream;
        bit acc;
        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(9) < 7)
                push(9'($urandom_range(XM + 5)), 8'($urandom_range(YM + 3)), 3'($urandom), acc);
            else
                @(negedge clk);
        end
        wait_drain(50, "random");
        total++; if (int'(clip_count) != exp_clip) begin bad++; $display("FAIL random_clip got=%0d want=%0d", clip_count, exp_clip); end
    endtask

    task automatic test_clip;
        bit acc;
        apply_reset();
        push(9'(XM), 8'd0, 3'd1, acc);
        push(9'd0, 8'(YM), 3'd2, acc);
        push(9'(XM - 1), 8'(YM - 1), 3'd4, acc);
        wait_drain(20, "clip");
        @(negedge clk);
        total++; if (int'(clip_count) != exp_clip) begin bad++; $display("FAIL clip_count got=%0d want=%0d", clip_count, exp_clip); end
    endtask

    task automatic test_clear_sweep;
        bit acc;
        int n_acc = 0;
        push(9'd5, 8'd5, 3'd1, acc);
        push(9'd6, 8'd6, 3'd2, acc);
        push(9'd7, 8'd7, 3'd3, acc);
        issue_clear(3'd0, 1'b1);
        total++; if (clear_busy !== 1'b1) begin bad++; $display("FAIL clear_busy_rise got=%0b want=1", clear_busy); end
        total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL wait_empty_ready got=%0b want=0", in_ready); end
        repeat (5) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            push(9'(i + 1), 8'(i + 2), 3'(i), acc);
            if (acc) n_acc++;
        end
        total++; if (n_acc != DP)         begin bad++; $display("FAIL clear_full_accepted got=%0d want=%0d", n_acc, DP); end
        total++; if (int'(level) != DP)   begin bad++; $display("FAIL clear_full_level got=%0d want=%0d", level, DP); end
        total++; if (in_ready !== 1'b0)   begin bad++; $display("FAIL clear_full_ready got=%0b want=0", in_ready); end
        issue_clear(3'd6, 1'b0);
        wait_drain(3000, "clear");
        @(negedge clk);
        total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL clear_busy_fall got=%0b want=0", clear_busy); end
        total++; if (level !== 5'd0)      begin bad++; $display("FAIL clear_end_level got=%0d want=0", level); end
        total++; if (vga_write !== 1'b0)  begin bad++; $display("FAIL clear_end_write got=%0b want=0", vga_write); end
    endtask

    task automatic test_reset_mid_clear;
        bit acc;
        bit found = 1'b0;
        issue_clear(3'd3, 1'b1);
        repeat (3) @(negedge clk);
        push(9'd2, 8'd3, 3'd4, acc);
        push(9'd4, 8'd5, 3'd6, acc);
        for (int i = 0; i < 2000 && !found; i++) begin
            @(negedge clk);
            if (vga_write && vga_x == 9'd10 && vga_y == 8'd5) found = 1'b1;
        end
        total++; if (!found) begin bad++; $display("FAIL midclear_reach got=0 want=1"); end
        #2 reset = 1'b1;
        #1;
        total++; if (vga_write !== 1'b0)  begin bad++; $display("FAIL midclear_write got=%0b want=0", vga_write); end
        total++; if (clear_busy !== 1'b0) begin bad++; $display("FAIL midclear_busy got=%0b want=0", clear_busy); end
        total++; if (level !== 5'd0)      begin bad++; $display("FAIL midclear_level got=%0d want=0", level); end
        exp_q.delete();
        exp_clip = 0;
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++; if (vga_write !== 1'b0)  begin bad++; $display("FAIL post_reset_write got=%0b want=0", vga_write); end
        @(negedge clk);
        push(9'd1, 8'd1, 3'd7, acc);
        total++; if (acc !== 1'b1) begin bad++; $display("FAIL post_reset_accept got=%0b want=1", acc); end
        wait_drain(20, "post_reset");
    endtask

    task automatic test_clip_saturate;
        bit acc;
        apply_reset();
        for (int i = 0; i < 256; i++)
            push(9'(XM + $urandom_range(20)), 8'($urandom_range(YM - 1)), 3'($urandom), acc);
        total++; if (int'(clip_count) != exp_clip) begin bad++; $display("FAIL sat_at_max got=%0d want=%0d", clip_count, exp_clip); end
        push(9'd0, 8'(YM + 1), 3'd2, acc);
        total++; if (int'(clip_count) != exp_clip) begin bad++; $display("FAIL sat_hold got=%0d want=%0d", clip_count, exp_clip); end
        total++; if (level !== 5'd0) begin bad++; $display("FAIL sat_level got=%0d want=0", level); end
    endtask

    initial begin
        test_reset();
        test_single_push();
        test_back_to_back();
        test_random_stream();
        test_clip();
        test_clear_sweep();
        test_reset_mid_clear();
        test_clip_saturate();
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL final_pending got=%0d want=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
